// File: rtl/wb_tlc_evt_sync_if.sv
// Event-channel bundle for wb_tlc_evt_sync: raw async levels, per-channel
// mode/clear controls, and synchronized level, pulse and sticky status.
interface wb_tlc_evt_sync_if #(
    parameter int NCH = 4
) ();
    logic [NCH-1:0]   async_in;
    logic [2*NCH-1:0] mode_i;
    logic [NCH-1:0]   clr_i;
    logic [NCH-1:0]   lvl_o;
    logic [NCH-1:0]   pulse_o;
    logic [NCH-1:0]   sts_o;
    logic [NCH-1:0]   drop_o;

    modport master (
        output async_in, mode_i, clr_i,
        input  lvl_o, pulse_o, sts_o, drop_o
    );

    modport slave (
        input  async_in, mode_i, clr_i,
        output lvl_o, pulse_o, sts_o, drop_o
    );
endinterface

// File: rtl/wb_tlc_evt_sync.sv
// Per-channel async event synchronizer with edge select, one-cycle pulse,
// holdoff suppression and sticky pulse/drop status.
module wb_tlc_evt_sync #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4
) (
    input  logic             clk_125,
    input  logic             rstn,
    wb_tlc_evt_sync_if.slave evt
);
    localparam logic [7:0] HOLD_LD = 8'(HOLDOFF);

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]                  prev_q;
    logic [NCH-1:0]                  pulse_q, pulse_d;
    logic [NCH-1:0]                  sts_q, sts_d;
    logic [NCH-1:0]                  drop_q, drop_d;
    logic [NCH-1:0][7:0]             hold_q, hold_d;
    logic [NCH-1:0]                  lvl, rise, fall, qual, drop_set;

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

    always_comb begin
        qual     = '0;
        pulse_d  = '0;
        drop_set = '0;
        hold_d   = hold_q;
        for (int c = 0; c < NCH; c++) begin
            qual[c]     = (rise[c] & evt.mode_i[2*c]) | (fall[c] & evt.mode_i[2*c+1]);
            pulse_d[c]  = qual[c] & (hold_q[c] == 8'd0);
            drop_set[c] = qual[c] & (hold_q[c] != 8'd0);
            // A channel switched off forgets any holdoff in progress.
            if (evt.mode_i[2*c +: 2] == 2'b00) begin
                hold_d[c] = 8'd0;
            end else if (pulse_d[c]) begin
                hold_d[c] = HOLD_LD;
            end else if (hold_q[c] != 8'd0) begin
                hold_d[c] = hold_q[c] - 8'd1;
            end
        end
        // Set beats clear when both land on the same edge.
        sts_d  = pulse_d  | (sts_q  & ~evt.clr_i);
        drop_d = drop_set | (drop_q & ~evt.clr_i);
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pulse_q <= '0;
            sts_q   <= '0;
            drop_q  <= '0;
            hold_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], evt.async_in};
            prev_q  <= lvl;
            pulse_q <= pulse_d;
            sts_q   <= sts_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
        end
    end

    assign evt.lvl_o   = lvl;
    assign evt.pulse_o = pulse_q;
    assign evt.sts_o   = sts_q;
    assign evt.drop_o  = drop_q;
endmodule

// File: tb/tb_wb_tlc_evt_sync.sv
// Directed bench for wb_tlc_evt_sync: a per-cycle vector table for the basic
// edge paths plus hand-written holdoff, clear, reset and zero-holdoff sequences.
module tb_wb_tlc_evt_sync;
    logic clk_125 = 1'b0;
    logic rstn    = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    wb_tlc_evt_sync_if #(.NCH(4)) evt ();
    wb_tlc_evt_sync_if #(.NCH(1)) evt1 ();

    wb_tlc_evt_sync #(.NCH(4), .SYNC_STAGES(2), .HOLDOFF(4)) dut (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .evt     (evt)
    );

    wb_tlc_evt_sync #(.NCH(1), .SYNC_STAGES(2), .HOLDOFF(0)) dut0 (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .evt     (evt1)
    );

    always #5 clk_125 = ~clk_125;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] m;
        logic [3:0] c;
        logic [3:0] lvl;
        logic [3:0] pls;
        logic [3:0] sts;
        logic [3:0] drp;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] m, input logic [3:0] c);
        evt.async_in = a;
        evt.mode_i   = m;
        evt.clr_i    = c;
    endtask

    task automatic chk_all(input string nm, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] s, input logic [3:0] d);
        chk({nm, ".lvl"},   evt.lvl_o,   l);
        chk({nm, ".pulse"}, evt.pulse_o, p);
        chk({nm, ".sts"},   evt.sts_o,   s);
        chk({nm, ".drop"},  evt.drop_o,  d);
    endtask

    initial begin
        // ch0 rising-only latency, falling ignored, then clear; ch1 falling-only
        tbl[0]  = '{4'h0, 8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'h1, 8'h01, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        tbl[4]  = '{4'h1, 8'h01, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
        tbl[5]  = '{4'h0, 8'h01, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
        tbl[6]  = '{4'h0, 8'h01, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[7]  = '{4'h0, 8'h01, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[8]  = '{4'h0, 8'h01, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{4'h2, 8'h08, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{4'h2, 8'h08, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{4'h2, 8'h08, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{4'h0, 8'h08, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{4'h0, 8'h08, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{4'h0, 8'h08, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
        tbl[15] = '{4'h0, 8'h08, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};

        drive(4'h0, 8'h00, 4'h0);
        evt1.async_in = 1'b0;
        evt1.mode_i   = 2'b11;
        evt1.clr_i    = 1'b0;

        #1 rstn = 1'b0;
        #3;
        chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk_125);
        @(negedge clk_125);
        rstn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].a, tbl[i].m, tbl[i].c);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].lvl, tbl[i].pls, tbl[i].sts, tbl[i].drp);
        end

        // ch3 both-edges: pulse, suppressed edge 2 cycles later, pulse once holdoff expires
        drive(4'h8, 8'hC0, 4'h0);
        tick();
        tick();
        chk("hold.lvl", evt.lvl_o, 4'h8);
        drive(4'h0, 8'hC0, 4'h0);
        tick();
        chk("hold.p1", evt.pulse_o, 4'h8);
        chk("hold.sts", evt.sts_o, 4'hA);
        tick();
        chk("hold.p1_off", evt.pulse_o, 4'h0);
        tick();
        chk("hold.supp", evt.pulse_o, 4'h0);
        chk("hold.drop", evt.drop_o, 4'h8);
        drive(4'h8, 8'hC0, 4'h0);
        tick();
        chk("hold.e6", evt.pulse_o, 4'h0);
        tick();
        chk("hold.e7", evt.pulse_o, 4'h0);
        tick();
        chk("hold.p2", evt.pulse_o, 4'h8);
        chk("hold.drop2", evt.drop_o, 4'h8);
        repeat (6) tick();

        // ch2 clear coinciding with set keeps sts; clear alone drops sts and drop
        drive(4'hC, 8'hD0, 4'h0);
        tick();
        tick();
        drive(4'hC, 8'hD0, 4'h4);
        tick();
        chk("clr.pulse", evt.pulse_o, 4'h4);
        chk("clr.sts_win", evt.sts_o, 4'hE);
        drive(4'hC, 8'hD0, 4'hC);
        tick();
        chk("clr.sts", evt.sts_o, 4'h2);
        chk("clr.drop", evt.drop_o, 4'h0);

        // enabling all channels on static levels must stay quiet
        drive(4'hC, 8'hD0, 4'hF);
        tick();
        drive(4'hC, 8'hFF, 4'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("enable.quiet%0d", k), evt.pulse_o, 4'h0);
        end
        chk("enable.sts", evt.sts_o, 4'h0);

        // all channels toggle together
        drive(4'h3, 8'hFF, 4'h0);
        tick();
        tick();
        tick();
        chk("all.pulse", evt.pulse_o, 4'hF);
        chk("all.sts", evt.sts_o, 4'hF);
        tick();
        chk("all.pulse_off", evt.pulse_o, 4'h0);

        // reset in mid-holdoff with inputs static
        #2 rstn = 1'b0;
        #1;
        chk_all("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk_125);
        @(negedge clk_125);
        chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
        rstn = 1'b1;
        tick();
        chk("rel.lvl1", evt.lvl_o, 4'h0);
        tick();
        chk("rel.lvl2", evt.lvl_o, 4'h3);
        chk("rel.nopulse", evt.pulse_o, 4'h0);
        tick();
        chk("rel.pulse", evt.pulse_o, 4'h3);
        chk("rel.drop", evt.drop_o, 4'h0);

        // mode 00 on ch0 wipes its holdoff; ch1 keeps counting and drops
        drive(4'h3, 8'hFC, 4'h0);
        tick();
        chk("off.sts_kept", evt.sts_o, 4'h3);
        drive(4'h0, 8'hFF, 4'h0);
        tick();
        tick();
        tick();
        chk("off.pulse", evt.pulse_o, 4'h1);
        chk("off.drop", evt.drop_o, 4'h2);

        // zero holdoff: back-to-back edges each pulse
        for (int k = 1; k <= 7; k++) begin
            if (k <= 4) evt1.async_in = ~evt1.async_in;
            tick();
            chk($sformatf("h0.e%0d", k), {3'b000, evt1.pulse_o},
                {3'b000, (k >= 3 && k <= 6) ? 1'b1 : 1'b0});
        end
        chk("h0.sts", {3'b000, evt1.sts_o}, 4'h1);
        chk("h0.drop", {3'b000, evt1.drop_o}, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
